// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one decimating FIR engine between two channels.
// Per-channel strobe gating and block counting live in fir_sched_lane.

module fir_sched_lane #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 grant,
  input  logic                 feed,
  input  logic                 wait_st,
  input  logic                 eng_x_rd_en,
  input  logic                 x_empty,
  input  logic                 eng_y_wr_en,
  input  logic                 y_full,
  output logic                 rd_en,
  output logic                 wr_en,
  output logic [CNT_WIDTH-1:0] blocks
);
  logic [CNT_WIDTH-1:0] blocks_d, blocks_q;

  assign rd_en  = feed & grant & eng_x_rd_en & ~x_empty;
  assign wr_en  = wait_st & grant & eng_y_wr_en & ~y_full;
  assign blocks = blocks_q;

  // An accepted write is exactly one completed block; the counter wraps.
  always_comb begin
    blocks_d = blocks_q;
    if (wr_en) blocks_d = blocks_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) blocks_q <= '0;
    else        blocks_q <= blocks_d;
  end
endmodule

module fir_channel_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int DECIMATION = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ch0_x_in,
  output logic                  ch0_x_in_rd_en,
  input  logic                  ch0_x_in_empty,
  input  logic [DATA_WIDTH-1:0] ch1_x_in,
  output logic                  ch1_x_in_rd_en,
  input  logic                  ch1_x_in_empty,
  output logic [DATA_WIDTH-1:0] ch0_y_out,
  output logic                  ch0_y_out_wr_en,
  input  logic                  ch0_y_out_full,
  output logic [DATA_WIDTH-1:0] ch1_y_out,
  output logic                  ch1_y_out_wr_en,
  input  logic                  ch1_y_out_full,
  output logic [DATA_WIDTH-1:0] eng_x,
  input  logic                  eng_x_rd_en,
  output logic                  eng_x_empty,
  input  logic [DATA_WIDTH-1:0] eng_y,
  input  logic                  eng_y_wr_en,
  output logic                  eng_y_full,
  output logic                  eng_sel,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  protocol_err,
  output logic [CNT_WIDTH-1:0]  ch0_blocks,
  output logic [CNT_WIDTH-1:0]  ch1_blocks
);
  localparam int NUM_CH = 2;
  localparam int DEC_W  = $clog2(DECIMATION + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT} state_t;

  state_t             state_d, state_q;
  logic               sel_d, sel_q;
  logic               last_d, last_q;
  logic [DEC_W-1:0]   cnt_d, cnt_q;
  logic [TMO_W-1:0]   wcnt_d, wcnt_q;
  logic               tmo_d, tmo_q;
  logic               perr_d, perr_q;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] x_in;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  blocks;
  logic [NUM_CH-1:0] x_empty, y_full, rd_en, wr_en, req;
  logic              feed, wait_st, rd_acc, wr_acc;

  assign x_in    = {ch1_x_in, ch0_x_in};
  assign x_empty = {ch1_x_in_empty, ch0_x_in_empty};
  assign y_full  = {ch1_y_out_full, ch0_y_out_full};
  assign req     = ~x_empty;
  assign feed    = (state_q == S_FEED);
  assign wait_st = (state_q == S_WAIT);
  assign rd_acc  = |rd_en;
  assign wr_acc  = |wr_en;

  // Data paths are always routed; only the strobes depend on state.
  assign eng_x        = x_in[sel_q];
  assign ch0_y_out    = eng_y;
  assign ch1_y_out    = eng_y;
  assign eng_x_empty  = feed ? x_empty[sel_q] : 1'b1;
  assign eng_y_full   = wait_st ? y_full[sel_q] : 1'b1;
  assign eng_sel      = sel_q;
  assign busy         = (state_q != S_IDLE);
  assign timeout_err  = tmo_q;
  assign protocol_err = perr_q;

  assign {ch1_x_in_rd_en, ch0_x_in_rd_en}   = rd_en;
  assign {ch1_y_out_wr_en, ch0_y_out_wr_en} = wr_en;
  assign ch0_blocks = blocks[0];
  assign ch1_blocks = blocks[1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    fir_sched_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clock      (clock),
      .reset      (reset),
      .grant      (sel_q == 1'(g)),
      .feed       (feed),
      .wait_st    (wait_st),
      .eng_x_rd_en(eng_x_rd_en),
      .x_empty    (x_empty[g]),
      .eng_y_wr_en(eng_y_wr_en),
      .y_full     (y_full[g]),
      .rd_en      (rd_en[g]),
      .wr_en      (wr_en[g]),
      .blocks     (blocks[g])
    );
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    perr_d  = perr_q | (eng_y_wr_en & ~wait_st) | (eng_x_rd_en & ~feed);
    case (state_q)
      S_IDLE: if (|req) begin
        // Contention goes to the channel not served last.
        sel_d   = (&req) ? ~last_q : req[1];
        cnt_d   = '0;
        wcnt_d  = '0;
        state_d = S_FEED;
      end
      S_FEED: if (rd_acc) begin
        if (cnt_q == DEC_W'(DECIMATION - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (wr_acc) begin
          last_d  = sel_q;
          wcnt_d  = '0;
          state_d = S_IDLE;
        end else if (wcnt_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          last_d  = sel_q;
          wcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      perr_q  <= perr_d;
    end
  end
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler: queue-backed FIFOs, a behavioural engine
// that sums each block of samples, and transaction-level expectations.

module tb_fir_channel_scheduler;
  localparam int DW = 32, DEC = 8, TMO = 64, CW = 16, DLY = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [DW-1:0] ch0_x_in = '0, ch1_x_in = '0;
  logic          ch0_x_in_empty = 1'b1, ch1_x_in_empty = 1'b1;
  logic          ch0_x_in_rd_en, ch1_x_in_rd_en;
  logic [DW-1:0] ch0_y_out, ch1_y_out;
  logic          ch0_y_out_wr_en, ch1_y_out_wr_en, ch0_y_out_full, ch1_y_out_full;
  logic [DW-1:0] eng_x, eng_y;
  logic          eng_x_rd_en, eng_x_empty, eng_y_wr_en, eng_y_full;
  logic          eng_sel, busy, timeout_err, protocol_err;
  logic [CW-1:0] ch0_blocks, ch1_blocks;

  fir_channel_scheduler #(.DATA_WIDTH(DW), .DECIMATION(DEC), .TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .ch0_x_in(ch0_x_in), .ch0_x_in_rd_en(ch0_x_in_rd_en), .ch0_x_in_empty(ch0_x_in_empty),
    .ch1_x_in(ch1_x_in), .ch1_x_in_rd_en(ch1_x_in_rd_en), .ch1_x_in_empty(ch1_x_in_empty),
    .ch0_y_out(ch0_y_out), .ch0_y_out_wr_en(ch0_y_out_wr_en), .ch0_y_out_full(ch0_y_out_full),
    .ch1_y_out(ch1_y_out), .ch1_y_out_wr_en(ch1_y_out_wr_en), .ch1_y_out_full(ch1_y_out_full),
    .eng_x(eng_x), .eng_x_rd_en(eng_x_rd_en), .eng_x_empty(eng_x_empty),
    .eng_y(eng_y), .eng_y_wr_en(eng_y_wr_en), .eng_y_full(eng_y_full),
    .eng_sel(eng_sel), .busy(busy), .timeout_err(timeout_err), .protocol_err(protocol_err),
    .ch0_blocks(ch0_blocks), .ch1_blocks(ch1_blocks)
  );

  int n_assert = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment state: FIFOs, engine, monitors
  logic [DW-1:0] xq0[$], xq1[$], yq0[$], yq1[$];
  bit   grants[$];
  logic full0 = 0, full1 = 0, rfull0 = 0, rfull1 = 0, rand_full = 0;
  logic eng_rd_on = 1, eng_hold = 0, wr_pulse = 0, eng_wr = 0;
  int   eng_reads = 0, eng_dly = 0;
  logic [DW-1:0] eng_acc = '0;
  int   rdcnt[2], wrcnt[2];
  logic busy_prev = 0;
  logic s_rd0, s_rd1, s_wr0, s_wr1, s_erd, s_ewr, s_busy;
  logic [DW-1:0] s_x, s_y;

  assign ch0_y_out_full = full0 | rfull0;
  assign ch1_y_out_full = full1 | rfull1;
  assign eng_x_rd_en    = eng_rd_on && (eng_reads < DEC) && !eng_x_empty;
  assign eng_y_wr_en    = eng_wr | wr_pulse;

  initial eng_y = '0;

  always begin : env
    @(negedge clock);
    s_rd0 = ch0_x_in_rd_en;  s_rd1 = ch1_x_in_rd_en;
    s_wr0 = ch0_y_out_wr_en; s_wr1 = ch1_y_out_wr_en;
    s_erd = eng_x_rd_en & ~eng_x_empty;
    s_ewr = eng_y_wr_en & ~eng_y_full;
    s_x = eng_x; s_y = eng_y; s_busy = busy;
    chk("route_x", eng_x, eng_sel ? ch1_x_in : ch0_x_in);
    chk("route_y", {ch1_y_out, ch0_y_out}, {eng_y, eng_y});
    chk("rd_gate", {s_rd1, s_rd0}, {s_erd & eng_sel, s_erd & ~eng_sel});
    chk("wr_gate", {s_wr1, s_wr0}, {s_ewr & eng_sel, s_ewr & ~eng_sel});
    if (busy && !busy_prev) grants.push_back(eng_sel);
    busy_prev = busy;
    @(posedge clock); #2;
    if (reset) begin
      if (s_rd0) begin void'(xq0.pop_front()); rdcnt[0]++; end
      if (s_rd1) begin void'(xq1.pop_front()); rdcnt[1]++; end
      if (s_wr0) begin yq0.push_back(s_y); wrcnt[0]++; end
      if (s_wr1) begin yq1.push_back(s_y); wrcnt[1]++; end
      if (s_erd) begin eng_acc = eng_acc + s_x; eng_reads++; eng_dly = DLY; end
      if (s_ewr || (eng_reads == DEC && !s_busy)) begin
        eng_wr = 0; eng_reads = 0; eng_acc = '0;
      end else if (eng_reads == DEC && !eng_wr && !eng_hold) begin
        if (eng_dly > 1) eng_dly--;
        else begin eng_wr = 1; eng_y = eng_acc; end
      end
    end else begin
      eng_wr = 0; eng_reads = 0; eng_acc = '0;
    end
    ch0_x_in = (xq0.size() > 0) ? xq0[0] : '0;
    ch1_x_in = (xq1.size() > 0) ? xq1[0] : '0;
    ch0_x_in_empty = (xq0.size() == 0);
    ch1_x_in_empty = (xq1.size() == 0);
    rfull0 = rand_full && ($urandom_range(0, 3) == 0);
    rfull1 = rand_full && ($urandom_range(0, 3) == 0);
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic clear_mon();
    rdcnt[0] = 0; rdcnt[1] = 0; wrcnt[0] = 0; wrcnt[1] = 0;
    grants.delete(); yq0.delete(); yq1.delete();
  endtask

  int sel_err;
  task automatic wait_idle(input string tag, input int exp_sel);
    bit done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clock);
      if (exp_sel >= 0 && busy && eng_sel !== exp_sel[0]) sel_err++;
      if (!busy && xq0.size() == 0 && xq1.size() == 0) done = 1;
    end
    chk({tag, "_bound"}, 64'(done), 64'd1);
  endtask

  task automatic wait_rd(input string tag, input int ch, input int n);
    bit done = 0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clock);
      if (rdcnt[ch] >= n) done = 1;
    end
    chk({tag, "_bound"}, 64'(done), 64'd1);
  endtask

  function automatic logic [DW-1:0] blk_sum(input logic [DW-1:0] q[$], input int b);
    logic [DW-1:0] s = '0;
    for (int k = 0; k < DEC; k++) s = s + q[b*DEC + k];
    return s;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  localparam logic [9:0] RST_VEC = 10'b0000110000;

  initial begin : stim
    logic [DW-1:0] ex0[$], ex1[$], v, s;
    bit eg[$];
    bit g, last;
    int n0, n1, rem0, rem1;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_flags", {busy, timeout_err, protocol_err, eng_sel, eng_x_empty, eng_y_full,
        ch0_x_in_rd_en, ch1_x_in_rd_en, ch0_y_out_wr_en, ch1_y_out_wr_en}, RST_VEC);
    chk("rst_blocks", {ch1_blocks, ch0_blocks}, '0);
    step(); reset = 1'b1;

    // Randomized round-robin: random block counts, random output backpressure
    clear_mon();
    n0 = $urandom_range(1, 3); n1 = $urandom_range(1, 3);
    for (int i = 0; i < n0*DEC; i++) begin v = $urandom; xq0.push_back(v); ex0.push_back(v); end
    for (int i = 0; i < n1*DEC; i++) begin v = $urandom; xq1.push_back(v); ex1.push_back(v); end
    rand_full = 1;
    rem0 = n0; rem1 = n1; last = 1;
    while (rem0 + rem1 > 0) begin
      g = (rem0 > 0 && rem1 > 0) ? !last : (rem0 > 0 ? 1'b0 : 1'b1);
      eg.push_back(g); last = g;
      if (g) rem1--; else rem0--;
    end
    wait_idle("A", -1);
    chk("A_blocks0", ch0_blocks, n0);
    chk("A_blocks1", ch1_blocks, n1);
    chk("A_ngrant", grants.size(), eg.size());
    foreach (eg[i]) chk("A_grant", grants[i], eg[i]);
    chk("A_ny0", yq0.size(), n0);
    chk("A_ny1", yq1.size(), n1);
    for (int b = 0; b < n0; b++) chk("A_y0", yq0[b], blk_sum(ex0, b));
    for (int b = 0; b < n1; b++) chk("A_y1", yq1[b], blk_sum(ex1, b));
    chk("A_errs", {timeout_err, protocol_err}, 2'b00);

    // Only ch1 requests right after reset
    step(); rand_full = 0; reset = 1'b0;
    step(); reset = 1'b1;
    clear_mon(); ex1.delete(); sel_err = 0;
    for (int i = 0; i < DEC; i++) begin v = $urandom; xq1.push_back(v); ex1.push_back(v); end
    wait_idle("B", 1);
    chk("B_sel", sel_err, 0);
    chk("B_rd", {32'(rdcnt[0]), 32'(rdcnt[1])}, {32'd0, 32'(DEC)});
    chk("B_blocks", {ch1_blocks, ch0_blocks}, {16'd1, 16'd0});
    chk("B_grant", {32'(grants.size()), 31'd0, grants[0]}, {32'd1, 32'd1});
    chk("B_y1", yq1[0], blk_sum(ex1, 0));
    chk("B_ny0", yq0.size(), 0);

    // ch0 runs dry mid-block, then is refilled
    step(); clear_mon(); ex0.delete();
    for (int i = 0; i < 5; i++) begin v = $urandom; xq0.push_back(v); ex0.push_back(v); end
    wait_rd("C_rd5", 0, 5);
    repeat (3) @(negedge clock);
    chk("C_stall", {busy, eng_x_empty, ch0_x_in_rd_en}, 3'b110);
    repeat (20) step();
    for (int i = 0; i < 3; i++) begin v = $urandom; xq0.push_back(v); ex0.push_back(v); end
    wait_idle("C", 0);
    chk("C_rd", rdcnt[0], DEC);
    chk("C_ngrant", grants.size(), 1);
    chk("C_blocks0", ch0_blocks, 1);
    chk("C_y0", yq0[0], blk_sum(ex0, 0));

    // Output full for 50 WAIT cycles while engine holds its write
    step(); clear_mon(); ex0.delete(); full0 = 1;
    for (int i = 0; i < DEC; i++) begin v = $urandom; xq0.push_back(v); ex0.push_back(v); end
    wait_rd("D_rd8", 0, DEC);
    repeat (50) @(negedge clock);
    chk("D_hold", {busy, eng_y_full, eng_y_wr_en, ch0_y_out_wr_en}, 4'b1110);
    chk("D_nowr", wrcnt[0], 0);
    step(); full0 = 0;
    @(negedge clock);
    chk("D_wr_on_release", ch0_y_out_wr_en, 1);
    @(negedge clock);
    chk("D_done", {busy, timeout_err, protocol_err}, 3'b000);
    chk("D_blocks0", ch0_blocks, 2);
    chk("D_y0", yq0[0], blk_sum(ex0, 0));

    // Engine never writes: watchdog abandons the block, ch1 served next
    step(); clear_mon(); ex1.delete(); eng_hold = 1;
    for (int i = 0; i < DEC; i++) begin v = $urandom; xq0.push_back(v); end
    wait_rd("E_rd8", 0, DEC);
    step();
    for (int i = 0; i < DEC; i++) begin v = $urandom; xq1.push_back(v); ex1.push_back(v); end
    repeat (TMO - 1) @(negedge clock);
    chk("E_pre_tmo", {timeout_err, busy}, 2'b01);
    @(negedge clock);
    chk("E_tmo", {timeout_err, busy}, 2'b10);
    step(); eng_hold = 0;
    wait_idle("E", -1);
    chk("E_blocks", {ch1_blocks, ch0_blocks}, {16'd2, 16'd2});
    chk("E_grants", {32'(grants.size()), 30'd0, grants[0], grants[1]}, {32'd2, 32'd1});
    chk("E_flags", {timeout_err, protocol_err}, 2'b10);
    chk("E_y1", yq1[0], blk_sum(ex1, 0));
    chk("E_nowr0", wrcnt[0], 0);

    // Reset mid-FEED, then a stray engine write in IDLE
    step(); clear_mon();
    for (int i = 0; i < DEC; i++) begin v = $urandom; xq0.push_back(v); end
    wait_rd("F_rd4", 0, 4);
    #1 reset = 1'b0;
    #1;
    chk("F_rst_flags", {busy, timeout_err, protocol_err, eng_sel, eng_x_empty, eng_y_full,
        ch0_x_in_rd_en, ch1_x_in_rd_en, ch0_y_out_wr_en, ch1_y_out_wr_en}, RST_VEC);
    chk("F_rst_blocks", {ch1_blocks, ch0_blocks}, '0);
    xq0.delete();
    step(); step(); reset = 1'b1;
    step(); wr_pulse = 1;
    @(negedge clock);
    chk("F_stray_wr", {ch1_y_out_wr_en, ch0_y_out_wr_en, protocol_err, busy}, 4'b0000);
    step(); wr_pulse = 0;
    @(negedge clock);
    chk("F_perr", {protocol_err, busy}, 2'b10);
    chk("F_nowr", wrcnt[0] + wrcnt[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
